dram_burst_checker: RTL and testbench

DRAM_BURST_CHECKER -- requirements
Module: dram_burst_checker

---
 rtl/dram_test_pkg.sv | 26 ++
 rtl/dram_pattern_gen.sv | 41 ++++
 rtl/dram_burst_checker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dram_burst_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_test_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dram_test_pkg
// Purpose  : Shared types and AXI4 encodings for the DRAM burst checker.
// Contents : state_t - checker sequencing states
//            OKAY / INCR / SIZE_4B - AXI4 response, burst and size codes
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package dram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B = 3'b010;

endpackage
`default_nettype wire

// File: rtl/dram_pattern_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dram_pattern_gen
// Purpose  : Combinational address/data pattern generator. Maps a burst index
//            and beat index onto the byte address of that beat and the data
//            word expected there (address XOR seed).
// Ports    : base_addr_i  - burst-aligned first byte address of the run
//            seed_i       - pattern seed
//            burst_idx_i  - burst number within the run
//            beat_idx_i   - beat number within the burst
//            burst_addr_o - byte address of beat 0 of the burst
//            beat_addr_o  - byte address of the selected beat
//            beat_data_o  - pattern word for the selected beat
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dram_pattern_gen #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      seed_i,
  input  logic [CNT_W-1:0] burst_idx_i,
  input  logic [7:0]       beat_idx_i,
  output logic [31:0]      burst_addr_o,
  output logic [31:0]      beat_addr_o,
  output logic [31:0]      beat_data_o
);

  // Bursts are BURST_LEN words long and BURST_LEN is a power of two, so the
  // per-burst stride is a plain shift. 32-bit arithmetic wraps modulo 2^32.
  localparam int c_ofs_w = $clog2(BURST_LEN * 4);

  logic [31:0] w_burst_off;

  assign w_burst_off  = 32'(burst_idx_i) << c_ofs_w;
  assign burst_addr_o = base_addr_i + w_burst_off;
  assign beat_addr_o  = burst_addr_o + {22'd0, beat_idx_i, 2'b00};
  assign beat_data_o  = beat_addr_o ^ seed_i;

endmodule
`default_nettype wire

// File: rtl/dram_burst_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dram_burst_checker
// Purpose  : AXI4 memory tester. Writes num_bursts INCR bursts of an
//            address-XOR-seed pattern starting at base_addr, reads them back,
//            and counts data mismatches and non-OKAY responses.
// Ports    : Clk, reset_rtl_0       - clock, asynchronous active-high reset
//            start, base_addr,
//            num_bursts, seed       - run request and run parameters
//            busy, done, pass       - run status
//            err_count,
//            first_err_addr         - error statistics of the last run
//            M_AXI_aw*/w*/b*        - AXI4 write master
//            M_AXI_ar*/r*           - AXI4 read master
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dram_burst_checker
  import dram_test_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             reset_rtl_0,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_bursts,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      first_err_addr,
  // AXI4 write channels
  output logic [31:0]      M_AXI_awaddr,
  output logic [7:0]       M_AXI_awlen,
  output logic [2:0]       M_AXI_awsize,
  output logic [1:0]       M_AXI_awburst,
  output logic             M_AXI_awvalid,
  input  logic             M_AXI_awready,
  output logic [31:0]      M_AXI_wdata,
  output logic [3:0]       M_AXI_wstrb,
  output logic             M_AXI_wlast,
  output logic             M_AXI_wvalid,
  input  logic             M_AXI_wready,
  input  logic [1:0]       M_AXI_bresp,
  input  logic             M_AXI_bvalid,
  output logic             M_AXI_bready,
  // AXI4 read channels
  output logic [31:0]      M_AXI_araddr,
  output logic [7:0]       M_AXI_arlen,
  output logic [2:0]       M_AXI_arsize,
  output logic [1:0]       M_AXI_arburst,
  output logic             M_AXI_arvalid,
  input  logic             M_AXI_arready,
  input  logic [31:0]      M_AXI_rdata,
  input  logic [1:0]       M_AXI_rresp,
  input  logic             M_AXI_rlast,
  input  logic             M_AXI_rvalid,
  output logic             M_AXI_rready
);

  localparam int          c_ofs_w      = $clog2(BURST_LEN * 4);
  localparam logic [31:0] c_align_mask = ~((32'd1 << c_ofs_w) - 32'd1);
  localparam logic [7:0]  c_last_beat  = 8'(BURST_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic [7:0]         beat_q, beat_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        seed_q, seed_d;
  logic [CNT_W-1:0]   nbursts_q, nbursts_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [31:0]        first_q, first_d;
  logic               pass_q, pass_d;

  logic               w_err_evt;
  logic [31:0]        w_err_addr;
  logic               w_last_burst;
  logic [31:0]        w_burst_addr;
  logic [31:0]        w_beat_addr;
  logic [31:0]        w_beat_data;

  dram_pattern_gen #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_pattern (
    .base_addr_i  (base_q),
    .seed_i       (seed_q),
    .burst_idx_i  (burst_q),
    .beat_idx_i   (beat_q),
    .burst_addr_o (w_burst_addr),
    .beat_addr_o  (w_beat_addr),
    .beat_data_o  (w_beat_data)
  );

  assign w_last_burst = (burst_q == (nbursts_q - CNT_W'(1)));

  // Fixed burst shape
  assign M_AXI_awlen   = c_last_beat;
  assign M_AXI_awsize  = SIZE_4B;
  assign M_AXI_awburst = INCR;
  assign M_AXI_arlen   = c_last_beat;
  assign M_AXI_arsize  = SIZE_4B;
  assign M_AXI_arburst = INCR;
  assign M_AXI_wstrb   = 4'hF;

  // Address and data come straight from registered burst/beat indices, so they
  // stay stable while the matching valid waits for ready.
  assign M_AXI_awaddr  = w_burst_addr;
  assign M_AXI_araddr  = w_burst_addr;
  assign M_AXI_wdata   = w_beat_data;
  assign M_AXI_wlast   = (state_q == ST_WR_DATA) && (beat_q == c_last_beat);

  assign busy           = (state_q != ST_IDLE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  always_ff @(posedge Clk or posedge reset_rtl_0) begin
    if (reset_rtl_0) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      nbursts_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      nbursts_q <= nbursts_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    base_d        = base_q;
    seed_d        = seed_q;
    nbursts_d     = nbursts_q;
    err_d         = err_q;
    first_d       = first_q;
    pass_d        = pass_q;
    w_err_evt     = 1'b0;
    w_err_addr    = w_beat_addr;
    M_AXI_awvalid = 1'b0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d    = base_addr & c_align_mask;
          seed_d    = seed;
          nbursts_d = num_bursts;
          burst_d   = '0;
          beat_d    = '0;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          state_d   = (num_bursts == '0) ? ST_DONE : ST_WR_ADDR;
        end
      end

      ST_WR_ADDR: begin
        M_AXI_awvalid = 1'b1;
        if (M_AXI_awready) begin
          beat_d  = '0;
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        M_AXI_wvalid = 1'b1;
        if (M_AXI_wready) begin
          if (beat_q == c_last_beat) begin
            beat_d  = '0;
            state_d = ST_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      ST_WR_RESP: begin
        M_AXI_bready = 1'b1;
        // A write response cannot be pinned to a single beat; report the
        // burst's first byte address.
        w_err_addr   = w_burst_addr;
        if (M_AXI_bvalid) begin
          w_err_evt = (M_AXI_bresp != OKAY);
          if (w_last_burst) begin
            burst_d = '0;
            state_d = ST_RD_ADDR;
          end else begin
            burst_d = burst_q + CNT_W'(1);
            state_d = ST_WR_ADDR;
          end
        end
      end

      ST_RD_ADDR: begin
        M_AXI_arvalid = 1'b1;
        if (M_AXI_arready) begin
          beat_d  = '0;
          state_d = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        M_AXI_rready = 1'b1;
        if (M_AXI_rvalid) begin
          // At most one error per beat, whatever combination went wrong.
          w_err_evt = (M_AXI_rdata != w_beat_data) || (M_AXI_rresp != OKAY) ||
                      (M_AXI_rlast && (beat_q != c_last_beat));
          if (M_AXI_rlast) begin
            beat_d = '0;
            if (w_last_burst) begin
              state_d = ST_DONE;
            end else begin
              burst_d = burst_q + CNT_W'(1);
              state_d = ST_RD_ADDR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // err_q only ever grows within a run, so zero means "no error yet".
    if (w_err_evt) begin
      if (err_q == '0) first_d = w_err_addr;
      if (err_q != '1) err_d = err_q + CNT_W'(1);
    end

    // Verdict is registered on entry to DONE so it is valid with the done pulse
    // and includes an error found on the final beat.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) pass_d = (err_d == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_dram_burst_checker
// Purpose  : Self-checking bench for dram_burst_checker with a memory-backed
//            AXI4 slave (stalls, read bit-flip and SLVERR injection).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dram_burst_checker;

  localparam int BL = 16;
  localparam int CW = 16;

  logic          Clk, reset_rtl_0, start;
  logic [31:0]   base_addr, seed;
  logic [CW-1:0] num_bursts;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [31:0]   first_err_addr;
  logic [31:0]   awaddr, wdata, araddr, rdata;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;

  dram_burst_checker #(.BURST_LEN(BL), .CNT_W(CW)) dut (
    .Clk(Clk), .reset_rtl_0(reset_rtl_0), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awsize(awsize),
    .M_AXI_awburst(awburst), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast),
    .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_bresp(bresp),
    .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arlen(arlen), .M_AXI_arsize(arsize),
    .M_AXI_arburst(arburst), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rlast(rlast),
    .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Main process acts 2 time units after each rising edge; the slave acts on
  // falling edges, so the two never touch shared state at the same instant.
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // ---------------- AXI slave model ----------------
  int          stall_pct = 0;
  bit          flip_en = 0;
  logic [31:0] flip_addr = '0;
  int          bresp_err_burst = -1;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log[$];
  logic [31:0] ar_log[$];
  logic [31:0] rq[$];
  logic [31:0] w_ptr = '0;
  int          w_beat = 0, r_beat = 0, b_cnt = 0, b_idx = 0;
  bit          w_open = 0, any_valid = 0;
  int          wlast_bad = 0, order_bad = 0;

  function automatic bit rnd_ok();
    return ($urandom_range(99) >= stall_pct);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  task automatic clear_slave();
    aw_log.delete(); ar_log.delete(); rq.delete(); mem.delete();
    w_beat = 0; r_beat = 0; b_cnt = 0; b_idx = 0; w_open = 0;
    wlast_bad = 0; order_bad = 0; any_valid = 0;
  endtask

  initial begin : slave
    logic [31:0] a;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge Clk);
      if (awvalid || wvalid || arvalid) any_valid = 1;
      // Each decision below holds until the next rising edge, so valid&ready
      // seen here is exactly the handshake that edge will complete.
      bvalid = (b_cnt > 0);
      bresp  = (b_idx == bresp_err_burst) ? 2'b10 : 2'b00;
      if (bvalid && bready) begin b_cnt--; b_idx++; end

      rvalid = (rq.size() > 0) && rnd_ok();
      rresp  = 2'b00;
      if (rq.size() > 0) begin
        a     = rq[0] + 32'(4 * r_beat);
        rdata = mem_rd(a) ^ ((flip_en && a == flip_addr) ? 32'd1 : 32'd0);
        rlast = (r_beat == BL - 1);
      end else rlast = 0;
      if (rvalid && rready) begin
        if (r_beat == BL - 1) begin r_beat = 0; void'(rq.pop_front()); end
        else r_beat++;
      end

      wready = rnd_ok();
      if (wvalid && wready) begin
        if (!w_open) order_bad++;
        mem[w_ptr + 32'(4 * w_beat)] = wdata;
        if (wlast != (w_beat == BL - 1)) wlast_bad++;
        if (w_beat == BL - 1) begin w_beat = 0; w_open = 0; b_cnt++; end
        else w_beat++;
      end

      awready = rnd_ok();
      if (awvalid && awready) begin aw_log.push_back(awaddr); w_ptr = awaddr; w_open = 1; w_beat = 0; end

      arready = rnd_ok();
      if (arvalid && arready) begin ar_log.push_back(araddr); rq.push_back(araddr); end
    end
  end

  // ---------------- one complete run ----------------
  task automatic run_test(input string nm, input logic [31:0] base, input int num,
                          input logic [31:0] sd, input int stall, input bit fen,
                          input logic [31:0] faddr, input int bburst, input int exp_err,
                          input logic [31:0] exp_first, input bit exp_pass);
    logic [31:0] abase, a;
    int cyc, bad;
    bit got_done;
    clear_slave();
    stall_pct = stall; flip_en = fen; flip_addr = faddr; bresp_err_burst = bburst;
    start = 1; base_addr = base; num_bursts = CW'(num); seed = sd;
    tick();
    start = 0;
    check({nm, " busy"}, busy, 1);
    got_done = 0; cyc = 0;
    while (!got_done && cyc < 4000) begin
      if (done) got_done = 1;
      else begin tick(); cyc++; end
    end
    check({nm, " done"}, got_done, 1);
    check({nm, " err_count"}, err_count, exp_err);
    check({nm, " first_err_addr"}, first_err_addr, exp_first);
    check({nm, " pass"}, pass, exp_pass);
    abase = base & ~32'(BL * 4 - 1);
    check({nm, " aw count"}, aw_log.size(), num);
    check({nm, " ar count"}, ar_log.size(), num);
    bad = 0;
    for (int k = 0; k < num; k++) begin
      a = abase + 32'(k * BL * 4);
      if (k >= aw_log.size() || aw_log[k] !== a) bad++;
      if (k >= ar_log.size() || ar_log[k] !== a) bad++;
    end
    check({nm, " burst addrs"}, bad, 0);
    bad = 0;
    for (int k = 0; k < num * BL; k++) begin
      a = abase + 32'(k * 4);
      if (mem_rd(a) !== (a ^ sd)) bad++;
    end
    check({nm, " written data"}, bad, 0);
    check({nm, " wlast/order"}, wlast_bad + order_bad, 0);
    tick();
    check({nm, " idle after done"}, {busy, done}, 2'b00);
    check({nm, " pass held"}, pass, exp_pass);
  endtask

  typedef struct {
    logic [31:0] base; int num; logic [31:0] sd; int stall; bit fen;
    logic [31:0] faddr; int bburst; int exp_err; logic [31:0] exp_first; bit exp_pass;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cyc, pulses;
    logic [31:0] rb, rs, rf, ab;
    int rn, rst_stall, rbb, re;
    bit rfe;

    reset_rtl_0 = 1; start = 0; base_addr = '0; num_bursts = '0; seed = '0;

    //           base          num seed          stall fen faddr        bburst err first        pass
    tbl.push_back('{32'h0000_0000, 4, 32'h0000_0000,  0, 0, 32'h0,        -1, 0, 32'h0,        1});
    tbl.push_back('{32'h0000_0000, 4, 32'h0000_0000,  0, 1, 32'h44,       -1, 1, 32'h44,       0});
    tbl.push_back('{32'h1000_0000, 3, 32'hA5A5_A5A5, 50, 0, 32'h0,        -1, 0, 32'h0,        1});
    tbl.push_back('{32'hFFFF_FFC0, 2, 32'hDEAD_BEEF, 20, 0, 32'h0,        -1, 0, 32'h0,        1});
    tbl.push_back('{32'h0000_4000, 3, 32'hA5A5_A5A5, 40, 1, 32'h4088,     -1, 1, 32'h4088,     0});
    tbl.push_back('{32'h0000_0000, 2, 32'h0000_0001,  0, 1, 32'h10,        1, 2, 32'h40,       0});
    tbl.push_back('{32'h0000_0123, 2, 32'h0000_1234,  0, 1, 32'h104,      -1, 1, 32'h104,      0});
    tbl.push_back('{32'h0000_0200, 3, 32'h0000_1234,  0, 0, 32'h0,         1, 1, 32'h240,      0});

    tick(); tick();
    check("reset outputs",
          {busy, done, pass, awvalid, wvalid, wlast, bready, arvalid, rready, err_count, first_err_addr}, '0);
    check("constant burst fields", {awlen, awsize, awburst, arlen, arsize, arburst, wstrb},
          {8'd15, 3'b010, 2'b01, 8'd15, 3'b010, 2'b01, 4'hF});
    reset_rtl_0 = 0;
    tick();

    foreach (tbl[i])
      run_test($sformatf("vec%0d", i), tbl[i].base, tbl[i].num, tbl[i].sd, tbl[i].stall,
               tbl[i].fen, tbl[i].faddr, tbl[i].bburst, tbl[i].exp_err, tbl[i].exp_first,
               tbl[i].exp_pass);

    // Zero-burst run right after a failing run: statistics must clear.
    clear_slave();
    start = 1; num_bursts = '0; base_addr = 32'h100; seed = 32'h5;
    tick();
    start = 0;
    check("num0 done next cycle", done, 1);
    check("num0 pass/err/first", {pass, err_count, first_err_addr}, {1'b1, 16'd0, 32'd0});
    tick();
    check("num0 done one cycle", {done, busy}, 2'b00);
    check("num0 no axi valids", any_valid, 0);

    // Second start while busy must be ignored.
    clear_slave(); stall_pct = 0; flip_en = 0; bresp_err_burst = -1;
    start = 1; base_addr = 32'h3000; num_bursts = 16'd2; seed = 32'h55;
    tick();
    start = 0;
    repeat (3) tick();
    start = 1; base_addr = 32'h8000; num_bursts = 16'd5;
    tick();
    start = 0;
    pulses = 0;
    for (int c = 0; c < 600; c++) begin
      if (done) pulses++;
      tick();
    end
    check("busy start done pulses", pulses, 1);
    check("busy start aw count", aw_log.size(), 2);
    check("busy start first aw", (aw_log.size() > 0) ? aw_log[0] : 32'hFFFF_FFFF, 32'h3000);
    check("busy start pass", {pass, err_count}, {1'b1, 16'd0});

    // Asynchronous reset while write data is in flight.
    clear_slave(); stall_pct = 30;
    start = 1; base_addr = 32'h0; num_bursts = 16'd4; seed = 32'h77;
    tick();
    start = 0;
    cyc = 0;
    while (!wvalid && cyc < 200) begin tick(); cyc++; end
    check("reached write data", wvalid, 1);
    reset_rtl_0 = 1;
    #1;
    check("async reset outputs",
          {busy, done, pass, awvalid, wvalid, wlast, bready, arvalid, rready, err_count, first_err_addr}, '0);
    tick(); tick();
    reset_rtl_0 = 0;
    clear_slave();
    tick();
    run_test("post reset", 32'h0000_0800, 2, 32'h0BAD_F00D, 25, 0, 32'h0, -1, 0, 32'h0, 1);

    // Randomised runs against a spec-level expectation: each flipped beat and
    // each SLVERR costs one error; writes precede reads, so a write error wins
    // the first-error address.
    for (int i = 0; i < 8; i++) begin
      rb = $urandom; rn = $urandom_range(1, 4); rs = $urandom;
      rst_stall = $urandom_range(0, 60);
      ab = rb & ~32'(BL * 4 - 1);
      rfe = 1'($urandom_range(0, 1));
      rf = ab + 32'($urandom_range(0, rn - 1) * BL * 4) + 32'($urandom_range(0, BL - 1) * 4);
      rbb = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rn - 1) : -1;
      re = int'(rfe) + ((rbb >= 0) ? 1 : 0);
      run_test($sformatf("rnd%0d", i), rb, rn, rs, rst_stall, rfe, rf, rbb, re,
               (rbb >= 0) ? ab + 32'(rbb * BL * 4) : (rfe ? rf : 32'h0), re == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
